uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 124 ++++++++++++
 tb/tb_uart_transmitter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, even parity, stop bit.
// Bit timing counts OVERSAMPLE sample_ENABLE ticks per serial bit.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_ENABLE,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [7:0]       data_q,  data_d;
  logic             par_q,   par_d;
  logic             txd_q,   txd_d;
  logic             busy_q,  busy_d;

  // Next-state: frame sequencing on tick boundaries, abort on Tx_EN low
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        if (Tx_EN && Tx_WR) begin
          state_d = START;
          data_d  = Tx_DATA;
          par_d   = ^Tx_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        if (!Tx_EN) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (sample_ENABLE) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (state_q)
              START: begin
                state_d = DATA;
                idx_d   = '0;
              end
              DATA: begin
                if (idx_q == IDX_W'(7)) begin
                  state_d = PARITY;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + IDX_W'(1);
                end
              end
              PARITY:  state_d = STOP;
              STOP:    state_d = IDLE;
              default: state_d = IDLE;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Line level and busy follow the state being entered, so they change with it
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_d[idx_d];
      PARITY:  txd_d = par_d;
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: tick-count frame model checked every cycle,
// plus directed frames with hand-computed bit sequences and durations.
module tb_uart_transmitter;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_ENABLE;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  uart_transmitter #(.OVERSAMPLE(OVS)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_ENABLE(sample_ENABLE),
    .Tx_EN        (Tx_EN),
    .Tx_WR        (Tx_WR),
    .Tx_DATA      (Tx_DATA),
    .TxD          (TxD),
    .Tx_BUSY      (Tx_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tick generator: one pulse every tick_period cycles
  int tick_period = 1;
  int tick_phase  = 0;
  always @(negedge clk) begin
    tick_phase    = (tick_phase + 1) % tick_period;
    sample_ENABLE = (tick_phase == 0);
  end

  // Model: a frame is 11 bits; bit n is on the line from tick n*OVS to (n+1)*OVS
  bit          m_active = 0;
  int          m_ticks  = 0;
  logic [10:0] m_bits   = '1;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0;
      m_ticks  = 0;
    end else if (!m_active) begin
      if (Tx_EN && Tx_WR) begin
        m_active = 1;
        m_ticks  = 0;
        m_bits   = {1'b1, ^Tx_DATA, Tx_DATA, 1'b0};
      end
    end else if (!Tx_EN) begin
      m_active = 0;
    end else if (sample_ENABLE) begin
      m_ticks++;
      if (m_ticks == 11 * OVS) m_active = 0;
    end
  end

  always @(negedge clk) begin
    check("model_txd", int'(TxD), m_active ? int'(m_bits[m_ticks / OVS]) : 1);
    check("model_busy", int'(Tx_BUSY), int'(m_active));
  end

  // Capture of the line during busy cycles
  int   busy_cnt = 0;
  logic cap[$];
  always @(negedge clk) begin
    if (Tx_BUSY) begin
      busy_cnt++;
      cap.push_back(TxD);
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    next_cycle();
    while (!sample_ENABLE) next_cycle();
    busy_cnt = 0;
    cap.delete();
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    next_cycle();
    Tx_WR   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (Tx_BUSY && n < limit) begin
      next_cycle();
      n++;
    end
    check("wait_idle_timeout", int'(Tx_BUSY), 0);
  endtask

  // Checks captured frame length and the mid-point of every bit
  task automatic check_frame(input string name, input logic [10:0] exp, input int bit_len);
    int idx;
    check({name, "_busy_len"}, busy_cnt, 11 * bit_len);
    for (int i = 0; i < 11; i++) begin
      idx = i * bit_len + bit_len / 2;
      if (idx < cap.size()) check($sformatf("%s_bit%0d", name, i), int'(cap[idx]), int'(exp[i]));
      else check($sformatf("%s_bit%0d_missing", name, i), idx, -1);
    end
  endtask

  initial begin
    int frames, gap, min_gap;
    bit prev_busy;
    reset   = 1'b0;
    Tx_EN   = 1'b1;
    Tx_WR   = 1'b0;
    Tx_DATA = 8'h00;
    repeat (3) next_cycle();
    check("reset_txd", int'(TxD), 1);
    check("reset_busy", int'(Tx_BUSY), 0);
    reset = 1'b1;
    repeat (2) next_cycle();

    // 0xA5, tick every cycle: 0,1,0,1,0,0,1,0,1,par 0,stop 1
    send(8'hA5);
    wait_idle(2000);
    check_frame("a5", 11'b1_0_10100101_0, 16);

    // 0x07, tick every 4th cycle: parity 1, 64-cycle bits
    tick_period = 4;
    send(8'h07);
    wait_idle(4000);
    check_frame("x07", 11'b1_1_00000111_0, 64);
    tick_period = 1;
    repeat (3) next_cycle();

    // Write of 0xFF mid-frame of 0x00 is ignored
    send(8'h00);
    repeat (50) next_cycle();
    Tx_DATA = 8'hFF;
    Tx_WR   = 1'b1;
    next_cycle();
    Tx_WR   = 1'b0;
    wait_idle(2000);
    check_frame("x00", 11'b1_0_00000000_0, 16);
    repeat (30) next_cycle();
    check("no_second_frame", busy_cnt, 176);

    // Tx_EN dropped during data bit 3 aborts on the next edge
    send(8'h5A);
    repeat (69) next_cycle();
    check("en_drop_busy_before", int'(Tx_BUSY), 1);
    Tx_EN = 1'b0;
    next_cycle();
    check("en_drop_txd", int'(TxD), 1);
    check("en_drop_busy", int'(Tx_BUSY), 0);
    busy_cnt = 0;
    Tx_DATA  = 8'h81;
    Tx_WR    = 1'b1;
    repeat (20) next_cycle();
    Tx_WR = 1'b0;
    check("wr_en_low_no_frame", busy_cnt, 0);
    Tx_EN = 1'b1;
    repeat (2) next_cycle();

    // Asynchronous reset during the parity bit, then a clean 0x3C frame
    send(8'h5A);
    repeat (149) next_cycle();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_txd", int'(TxD), 1);
    check("async_rst_busy", int'(Tx_BUSY), 0);
    next_cycle();
    reset = 1'b1;
    repeat (2) next_cycle();
    send(8'h3C);
    wait_idle(2000);
    check_frame("x3c", 11'b1_0_00111100_0, 16);

    // Tx_WR held high: back-to-back frames with an idle gap between them
    Tx_DATA   = 8'h96;
    Tx_WR     = 1'b1;
    frames    = 0;
    gap       = 0;
    min_gap   = 1000;
    prev_busy = 1'b0;
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      if (Tx_BUSY && !prev_busy) begin
        if (frames > 0 && gap < min_gap) min_gap = gap;
        frames++;
        gap = 0;
      end else if (!Tx_BUSY) begin
        gap++;
      end
      prev_busy = Tx_BUSY;
    end
    Tx_WR = 1'b0;
    wait_idle(2000);
    check("b2b_frames", int'(frames >= 3), 1);
    check("b2b_gap", int'(min_gap >= 1 && min_gap < 1000), 1);

    repeat (5) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
